// File: rtl/apb_gpio_param.sv
// apb_gpio_param: parametrised APB GPIO slave with per-pin output enable, AUX output mux,
// input synchroniser and per-pin edge/level interrupts.
// Optional feature macro: GPIO_DEBOUNCE_EN adds register 0x28 DBEN and a per-pin input debounce filter.
// Ports:
//   pclk, preset          APB clock, asynchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr, pwdata         byte address (paddr[5:2] decoded), write data
//   pready, prdata, pslverr  transfer complete, read data, error (valid while pready)
//   aux_in                alternate output sources selected per pin by AUX
//   gpio_in               asynchronous pad inputs
//   gpio_out, gpio_oe     pad output data and output enable
//   irq                   interrupt request
module apb_gpio_param #(
    parameter int GPIO_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_STATES = 0,
    parameter int DB_CYCLES   = 4
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       paddr,
    input  logic [31:0]       pwdata,
    input  logic [GPIO_W-1:0] aux_in,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);
    logic [2:0]        cnt;
    logic [3:0]        idx;
    logic              hit, wr;
    logic [31:0]       rd;
    logic              gie;
    logic [GPIO_W-1:0] out_r, oe_r, inte_r, ptrig_r, aux_r, ints_r, both_r, level_r;
    logic [GPIO_W-1:0] sync_r [SYNC_STAGES];
    logic [GPIO_W-1:0] s_in, val, prev, ev, clr;
    logic              unused;

    assign unused = ^{paddr[31:6], paddr[1:0], pwdata};
    assign idx    = paddr[5:2];
    assign pready = psel & penable & (cnt == 3'(WAIT_STATES));
    assign wr     = pready & pwrite & hit;
    assign prdata = (pready && hit) ? rd : '0;
    assign pslverr = pready & ~hit;
    assign gpio_out = (aux_r & aux_in) | (~aux_r & out_r);
    assign gpio_oe  = oe_r;
    assign irq      = gie & |ints_r;
    assign s_in     = sync_r[SYNC_STAGES-1];
    assign clr      = (wr && idx == 4'h7) ? pwdata[GPIO_W-1:0] : '0;
    // LEVEL takes priority over BOTH, which takes priority over the single-edge mode.
    assign ev = (level_r & ~(val ^ ptrig_r))
              | (~level_r & both_r & (val ^ prev))
              | (~level_r & ~both_r & ((ptrig_r & val & ~prev) | (~ptrig_r & ~val & prev)));

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [GPIO_W-1:0] dben_r, filt;
    logic [CW-1:0]     db_cnt [GPIO_W];
    assign val = (dben_r & filt) | (~dben_r & s_in);
    // The counter tracks consecutive samples that differ from the filtered value;
    // the filter flips on the DB_CYCLES-th such sample.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            filt <= '0;
            for (int i = 0; i < GPIO_W; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < GPIO_W; i++) begin
                if (s_in[i] == filt[i]) db_cnt[i] <= '0;
                else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    filt[i]   <= s_in[i];
                    db_cnt[i] <= '0;
                end else db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign val = s_in;
`endif

    always_comb begin
        rd  = '0;
        hit = 1'b1;
        case (idx)
            4'h0: rd = 32'(val);
            4'h1: rd = 32'(out_r);
            4'h2: rd = 32'(oe_r);
            4'h3: rd = 32'(inte_r);
            4'h4: rd = 32'(ptrig_r);
            4'h5: rd = 32'(aux_r);
            4'h6: rd = {30'd0, |ints_r, gie};
            4'h7: rd = 32'(ints_r);
            4'h8: rd = 32'(both_r);
            4'h9: rd = 32'(level_r);
`ifdef GPIO_DEBOUNCE_EN
            4'ha: rd = 32'(dben_r);
`endif
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) cnt <= '0;
        else if (!psel || pready) cnt <= '0;
        else if (penable) cnt <= cnt + 3'd1;
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= '0;
            prev   <= '0;
            ints_r <= '0;
        end else begin
            sync_r[0] <= gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
            prev   <= val;
            // A new event in the same cycle as a W1C clear keeps the bit set.
            ints_r <= (ints_r & ~clr) | (inte_r & ev);
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            out_r   <= '0;
            oe_r    <= '0;
            inte_r  <= '0;
            ptrig_r <= '0;
            aux_r   <= '0;
            both_r  <= '0;
            level_r <= '0;
            gie     <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
            dben_r  <= '0;
`endif
        end else if (wr) begin
            case (idx)
                4'h1: out_r   <= pwdata[GPIO_W-1:0];
                4'h2: oe_r    <= pwdata[GPIO_W-1:0];
                4'h3: inte_r  <= pwdata[GPIO_W-1:0];
                4'h4: ptrig_r <= pwdata[GPIO_W-1:0];
                4'h5: aux_r   <= pwdata[GPIO_W-1:0];
                4'h6: gie     <= pwdata[0];
                4'h8: both_r  <= pwdata[GPIO_W-1:0];
                4'h9: level_r <= pwdata[GPIO_W-1:0];
`ifdef GPIO_DEBOUNCE_EN
                4'ha: dben_r  <= pwdata[GPIO_W-1:0];
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_gpio_param.sv
// tb_apb_gpio_param: scoreboard bench for apb_gpio_param (GPIO_W=32, SYNC_STAGES=2, WAIT_STATES=2).
module tb_apb_gpio_param;
    logic        pclk = 0, preset = 0, psel = 0, penable = 0, pwrite = 0;
    logic [31:0] paddr = 0, pwdata = 0, aux_in = 0, gpio_in = 0;
    logic        pready, pslverr, irq;
    logic [31:0] prdata, gpio_out, gpio_oe;

    typedef struct {logic rd; logic [31:0] data; logic err; logic [5:0] addr;} exp_t;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0;

    apb_gpio_param #(.GPIO_W(32), .SYNC_STAGES(2), .WAIT_STATES(2), .DB_CYCLES(4)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .aux_in(aux_in), .gpio_in(gpio_in),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (preset && psel && penable && pready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pready addr=%h got=1 want=0", paddr);
            end else begin
                e = q.pop_front();
                chk($sformatf("pslverr@%h", e.addr), 32'(pslverr), 32'(e.err));
                if (e.rd) chk($sformatf("prdata@%h", e.addr), prdata, e.data);
            end
        end
    end

    task automatic apb(input logic w, input logic [5:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee);
        int cyc;
        q.push_back('{!w, ed, ee, a});
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = w; paddr = 32'(a); pwdata = d;
        @(posedge pclk); #1;
        penable = 1;
        cyc = 1;
        while (!pready && cyc < 10) begin
            @(posedge pclk); #1;
            cyc++;
        end
        chk("access_cycles", 32'(cyc), 32'd3);
        @(posedge pclk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        apb(1'b1, a, d, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] ed);
        apb(1'b0, a, 32'd0, ed, 1'b0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        cyc(3);
        preset = 1;
        chk("rst_out", gpio_out, 0);
        chk("rst_oe", gpio_oe, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_pready", 32'(pready), 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_pslverr", 32'(pslverr), 0);
        rd(6'h04, 0);
        rd(6'h1C, 0);
        rd(6'h18, 0);

        wr(6'h08, 32'h0000FFFF);
        wr(6'h04, 32'hA5A5A5A5);
        chk("oe", gpio_oe, 32'h0000FFFF);
        chk("out", gpio_out, 32'hA5A5A5A5);
        rd(6'h04, 32'hA5A5A5A5);
        rd(6'h08, 32'h0000FFFF);
        aux_in = 32'hF0F0F0F0;
        wr(6'h14, 32'hFFFF0000);
        chk("aux_mux", gpio_out, 32'hF0F0A5A5);
        rd(6'h14, 32'hFFFF0000);
        wr(6'h14, 0);
        chk("aux_off", gpio_out, 32'hA5A5A5A5);

        fork begin cyc(2); gpio_in = 32'h12345678; end join_none
        rd(6'h00, 32'h12345678);
        fork begin cyc(3); gpio_in = 0; end join_none
        rd(6'h00, 32'h12345678);
        rd(6'h00, 0);
        wr(6'h00, 32'hFFFFFFFF);
        rd(6'h00, 0);
        apb(1'b0, 6'h2C, 0, 0, 1'b1);
        apb(1'b1, 6'h2C, 32'hFFFFFFFF, 0, 1'b1);
`ifndef GPIO_DEBOUNCE_EN
        apb(1'b0, 6'h28, 0, 0, 1'b1);
`endif

        wr(6'h0C, 32'hFF);
        wr(6'h10, 32'h01);
        wr(6'h20, 32'h02);
        wr(6'h18, 32'h1);
        @(posedge pclk); #1;
        gpio_in = 1;
        cyc(1);
        chk("irq_lat1", 32'(irq), 0);
        cyc(1);
        chk("irq_lat2", 32'(irq), 0);
        cyc(1);
        chk("irq_lat3", 32'(irq), 1);
        rd(6'h1C, 32'h1);
        gpio_in = 0;
        cyc(4);
        rd(6'h1C, 32'h1);
        gpio_in = 2;
        cyc(4);
        rd(6'h1C, 32'h3);
        wr(6'h1C, 32'h3);
        chk("irq_cleared", 32'(irq), 0);
        rd(6'h1C, 0);
        gpio_in = 0;
        cyc(4);
        rd(6'h1C, 32'h2);
        wr(6'h1C, 32'h2);
        rd(6'h1C, 0);

        wr(6'h24, 32'h04);
        wr(6'h10, 32'h04);
        gpio_in = 4;
        cyc(4);
        rd(6'h1C, 32'h4);
        wr(6'h1C, 32'h4);
        rd(6'h1C, 32'h4);
        wr(6'h24, 0);
        wr(6'h1C, 32'h4);
        rd(6'h1C, 0);

        gpio_in = 6;
        cyc(4);
        rd(6'h1C, 32'h2);
        fork begin cyc(2); gpio_in = 4; end join_none
        wr(6'h1C, 32'h2);
        rd(6'h1C, 32'h2);

        wr(6'h18, 0);
        chk("irq_masked", 32'(irq), 0);
        rd(6'h18, 32'h2);
        rd(6'h1C, 32'h2);
        wr(6'h18, 32'h1);
        chk("irq_unmasked", 32'(irq), 1);
        wr(6'h1C, 32'h2);
        chk("irq_final", 32'(irq), 0);

        @(posedge pclk); #1;
        psel = 1; pwrite = 1; paddr = 32'h04; pwdata = 32'h12345678;
        @(posedge pclk); #1;
        penable = 1;
        @(posedge pclk); #1;
        preset = 0;
        #1;
        psel = 0; penable = 0; pwrite = 0;
        chk("rst_abort_out", gpio_out, 0);
        @(posedge pclk); #1;
        preset = 1;
        rd(6'h04, 0);

`ifdef GPIO_DEBOUNCE_EN
        gpio_in = 0;
        wr(6'h28, 32'h1);
        rd(6'h28, 32'h1);
        gpio_in = 1;
        cyc(2);
        gpio_in = 0;
        cyc(8);
        rd(6'h00, 0);
        gpio_in = 1;
        cyc(10);
        rd(6'h00, 32'h1);
`endif

        cyc(2);
        chk("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
